capture_fifo: RTL

CAPTURE_FIFO -- requirements
Module: capture_fifo

---
 rtl/capture_fifo.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : capture_fifo
// Brief    : Wishbone-mapped FIFO that captures count_i on edges of an
//            asynchronous event pad input, with threshold/overflow interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module capture_fifo #(
    parameter int BITS  = 32,
    parameter int DEPTH = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rstn_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [BITS-1:0] count_i,
    input  logic            evt_i,
    output logic            irq_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    localparam logic [1:0]       c_adr_data   = 2'd0;
    localparam logic [1:0]       c_adr_status = 2'd1;
    localparam logic [1:0]       c_adr_ctrl   = 2'd2;
    localparam logic [LVL_W-1:0] c_depth      = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_last   = PTR_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_irq;
    logic             r_en;
    logic             r_edge_sel;
    logic             r_irq_en;
    logic [3:0]       r_thresh;
    logic             r_ovf;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [BITS-1:0]  r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        w_valid;
    logic        w_acc;
    logic        w_rd;
    logic        w_wr;
    logic [1:0]  w_adr;
    logic        w_ctrl_wr;
    logic        w_stat_wr;
    logic        w_flush;
    logic        w_ovf_clr;
    logic [31:0] w_rdata;

    assign w_valid   = wbs_cyc_i & wbs_stb_i;
    assign w_acc     = w_valid & ~r_ack;
    assign w_rd      = w_acc & ~wbs_we_i;
    assign w_wr      = w_acc & wbs_we_i;
    assign w_adr     = wbs_adr_i[3:2];
    assign w_ctrl_wr = w_wr & (w_adr == c_adr_ctrl);
    assign w_stat_wr = w_wr & (w_adr == c_adr_status);
    assign w_flush   = w_ctrl_wr & wbs_sel_i[1] & wbs_dat_i[8];
    assign w_ovf_clr = w_stat_wr & wbs_sel_i[2] & wbs_dat_i[16];

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_edge;
    logic w_pop;
    logic w_push_req;
    logic w_push;
    logic w_drop;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == c_depth);
    assign w_edge     = r_edge_sel ? (~r_sync2 & r_prev) : (r_sync2 & ~r_prev);
    assign w_pop      = w_rd & (w_adr == c_adr_data) & ~w_empty;
    // A flush in the same cycle swallows the capture without flagging overflow
    assign w_push_req = r_en & w_edge & ~w_flush;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            c_adr_data: begin
                if (!w_empty) begin
                    w_rdata = 32'(r_mem[r_rd_ptr]);
                end
            end
            c_adr_status: begin
                w_rdata[3:0] = 4'(r_level);
                w_rdata[8]   = w_empty;
                w_rdata[9]   = w_full;
                w_rdata[16]  = r_ovf;
            end
            c_adr_ctrl: begin
                w_rdata[0]   = r_en;
                w_rdata[1]   = r_edge_sel;
                w_rdata[2]   = r_irq_en;
                w_rdata[7:4] = r_thresh;
            end
            default: w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Wishbone response
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_rd) begin
                r_dat <= w_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_en       <= 1'b0;
            r_edge_sel <= 1'b0;
            r_irq_en   <= 1'b0;
            r_thresh   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_ctrl_wr && wbs_sel_i[0]) begin
                r_en       <= wbs_dat_i[0];
                r_edge_sel <= wbs_dat_i[1];
                r_irq_en   <= wbs_dat_i[2];
                r_thresh   <= wbs_dat_i[7:4];
            end
            // A drop in the clearing cycle wins so no overflow goes unseen
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event synchronizer and edge history
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= evt_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and level
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers define which entries are live
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= count_i;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en &
                     (((r_thresh != 4'd0) & (4'(r_level) >= r_thresh)) | r_ovf);
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_irq;

    logic w_unused_ok;
    assign w_unused_ok = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:17],
                           wbs_dat_i[15:9], wbs_dat_i[3], wbs_sel_i[3]};

endmodule
`default_nettype wire
